viterbi_link_ctrl: RTL and testbench

VITERBI_LINK_CTRL -- requirements
Module: viterbi_link_ctrl

---
 rtl/viterbi_link_ctrl_pkg.sv | 30 +++
 rtl/viterbi_link_ctrl_prbs7.sv | 34 +++
 rtl/viterbi_link_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_viterbi_link_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/viterbi_link_ctrl_pkg.sv
// Shared types and constants for the Viterbi link controller: FSM states,
// PRBS7 definition, counter sizing and the channel flip mask.
package viterbi_link_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_HI = 6;   // x^7 term
  localparam int         PRBS_TAP_LO = 5;   // x^6 term

  localparam int                CNT_W   = 9;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  localparam logic [1:0] FLIP_MASK = 2'b10;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/viterbi_link_ctrl_prbs7.sv
// PRBS7 (x^7+x^6+1) generator; bit_o is the register MSB.
module prbs7_gen
  import viterbi_link_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic seed_load,
  input  logic advance,
  output logic bit_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = PRBS_SEED;
    end else if (advance) begin
      lfsr_d = prbs7_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= PRBS_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[6];

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Link test controller: streams PRBS7 bits into an encoder with periodic
// channel-error injection and checks the decoder output after a fixed latency.
module viterbi_link_ctrl
  import viterbi_link_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       frame_len,
  input  logic [7:0]       dec_latency,
  input  logic [3:0]       err_period,
  input  logic [3:0]       err_burst,
  input  logic             decoder_o,
  output logic             encoder_i,
  output logic             enable_encoder_i,
  output logic [1:0]       err_mask,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_err_ct,
  output logic [CNT_W-1:0] chan_err_ct
);

  state_t           state_q, state_d;
  logic [8:0]       tx_left_q, tx_left_d;
  logic [8:0]       cmp_left_q, cmp_left_d;
  logic [7:0]       cmp_wait_q, cmp_wait_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       period_q, period_d;
  logic [3:0]       burst_q, burst_d;
  logic             encoder_q, encoder_d;
  logic             enable_q, enable_d;
  logic [1:0]       mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] bit_err_q, bit_err_d;
  logic [CNT_W-1:0] chan_err_q, chan_err_d;

  logic       tx_bit, chk_bit;
  logic       accept, active, kill, tx_more, cmp_now;
  logic       tx_seed, tx_adv;
  logic [8:0] eff_len;
  logic [7:0] eff_lat;

  function automatic logic [1:0] inject_mask(input logic [3:0] ph,
                                             input logic [3:0] per,
                                             input logic [3:0] bur);
    return (per != 4'd0 && ph < bur) ? FLIP_MASK : 2'b00;
  endfunction

  function automatic logic [3:0] phase_step(input logic [3:0] ph, input logic [3:0] per);
    return (ph + 4'd1 == per) ? 4'd0 : ph + 4'd1;
  endfunction

  assign eff_len = (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
  assign eff_lat = (dec_latency == 8'd0) ? 8'd1 : dec_latency;

  assign accept  = (state_q == IDLE) && start;
  assign active  = (state_q == RUN) || (state_q == DRAIN);
  assign kill    = active && abort;
  assign tx_more = (state_q == RUN) && !abort && (tx_left_q > 9'd1);
  assign cmp_now = active && !abort && (cmp_wait_q == 8'd0) && (cmp_left_q != 9'd0);

  // The tx generator is parked at the seed outside a frame so that bit 0 is
  // already on its output when the accepting edge registers it.
  assign tx_seed = ((state_q == IDLE) && !start) || (state_q == DONE) || kill;
  assign tx_adv  = accept || tx_more;

  prbs7_gen u_tx_prbs (
    .clk       (clk),
    .rst       (rst),
    .seed_load (tx_seed),
    .advance   (tx_adv),
    .bit_o     (tx_bit)
  );

  prbs7_gen u_chk_prbs (
    .clk       (clk),
    .rst       (rst),
    .seed_load (accept),
    .advance   (cmp_now),
    .bit_o     (chk_bit)
  );

  always_comb begin
    state_d    = state_q;
    tx_left_d  = tx_left_q;
    cmp_left_d = cmp_left_q;
    cmp_wait_d = cmp_wait_q;
    phase_d    = phase_q;
    period_d   = period_q;
    burst_d    = burst_q;
    bit_err_d  = bit_err_q;
    chan_err_d = chan_err_q;
    encoder_d  = 1'b0;
    enable_d   = 1'b0;
    mask_d     = 2'b00;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          tx_left_d  = eff_len;
          cmp_left_d = eff_len;
          cmp_wait_d = eff_lat;
          period_d   = err_period;
          burst_d    = err_burst;
          enable_d   = 1'b1;
          encoder_d  = tx_bit;
          mask_d     = inject_mask(4'd0, err_period, err_burst);
          phase_d    = phase_step(4'd0, err_period);
          bit_err_d  = '0;
          chan_err_d = (mask_d != 2'b00) ? CNT_ONE : '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tx_left_d = tx_left_q - 9'd1;
          if (tx_more) begin
            enable_d  = 1'b1;
            encoder_d = tx_bit;
            mask_d    = inject_mask(phase_q, period_q, burst_q);
            phase_d   = phase_step(phase_q, period_q);
            if (mask_d != 2'b00) begin
              chan_err_d = sat_inc(chan_err_q);
            end
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cmp_now && cmp_left_q == 9'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Compare path runs in parallel with transmit whenever a frame is live.
    if (active && !abort) begin
      if (cmp_wait_q != 8'd0) begin
        cmp_wait_d = cmp_wait_q - 8'd1;
      end
      if (cmp_now) begin
        cmp_left_d = cmp_left_q - 9'd1;
        if (decoder_o != chk_bit) begin
          bit_err_d = sat_inc(bit_err_q);
        end
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_left_q  <= '0;
      cmp_left_q <= '0;
      cmp_wait_q <= '0;
      phase_q    <= '0;
      period_q   <= '0;
      burst_q    <= '0;
      encoder_q  <= 1'b0;
      enable_q   <= 1'b0;
      mask_q     <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bit_err_q  <= '0;
      chan_err_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_left_q  <= tx_left_d;
      cmp_left_q <= cmp_left_d;
      cmp_wait_q <= cmp_wait_d;
      phase_q    <= phase_d;
      period_q   <= period_d;
      burst_q    <= burst_d;
      encoder_q  <= encoder_d;
      enable_q   <= enable_d;
      mask_q     <= mask_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bit_err_q  <= bit_err_d;
      chan_err_q <= chan_err_d;
    end
  end

  assign encoder_i        = encoder_q;
  assign enable_encoder_i = enable_q;
  assign err_mask         = mask_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign bit_err_ct       = bit_err_q;
  assign chan_err_ct      = chan_err_q;

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Self-checking bench for viterbi_link_ctrl: directed and random frames checked
// cycle by cycle against a frame-level reference built from the link rules.
module tb_viterbi_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic [7:0] dec_latency = 8'd0;
  logic [3:0] err_period = 4'd0;
  logic [3:0] err_burst = 4'd0;
  logic       decoder_o = 1'b0;
  logic       encoder_i, enable_encoder_i, busy, done;
  logic [1:0] err_mask;
  logic [8:0] bit_err_ct, chan_err_ct;

  int errors = 0;
  int checks = 0;
  int frame_no = 0;
  bit tx_ref [256];

  always #5 clk = ~clk;

  viterbi_link_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .frame_len        (frame_len),
    .dec_latency      (dec_latency),
    .err_period       (err_period),
    .err_burst        (err_burst),
    .decoder_o        (decoder_o),
    .encoder_i        (encoder_i),
    .enable_encoder_i (enable_encoder_i),
    .err_mask         (err_mask),
    .busy             (busy),
    .done             (done),
    .bit_err_ct       (bit_err_ct),
    .chan_err_ct      (chan_err_ct)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s frame=%0d got=%0d exp=%0d", tag, frame_no, got, exp);
    end
  endtask

  // PRBS7 x^7+x^6+1 from seed 0x7F, output = MSB, shift toward MSB.
  task automatic build_prbs_ref();
    int s;
    s = 'h7F;
    for (int i = 0; i < 256; i++) begin
      tx_ref[i] = bit'((s >> 6) & 1);
      s = ((s << 1) | (((s >> 6) ^ (s >> 5)) & 1)) & 'h7F;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_enable"}, int'(enable_encoder_i), 0);
    check({tag, "_encoder"}, int'(encoder_i), 0);
    check({tag, "_mask"}, int'(err_mask), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic run_frame(input int len_cfg, input int lat_cfg, input int per, input int bur,
                           input int flip_pct, input logic [255:0] flip_vec,
                           input int abort_at, input int restart_at);
    int len, lat, exp_chan, exp_bit, last_c, k;
    bit flip [256];
    len = (len_cfg == 0) ? 256 : len_cfg;
    lat = (lat_cfg == 0) ? 1 : lat_cfg;
    for (int i = 0; i < 256; i++)
      flip[i] = flip_vec[i] | (int'($urandom_range(0, 99)) < flip_pct);
    exp_chan = 0;
    exp_bit  = 0;
    for (int i = 0; i < len; i++) begin
      if ((abort_at < 0 || i <= abort_at) && per != 0 && (i % per) < bur) exp_chan++;
      if ((abort_at < 0 || i + lat < abort_at) && flip[i]) exp_bit++;
    end
    if (exp_chan > 511) exp_chan = 511;
    if (exp_bit > 511) exp_bit = 511;
    last_c = (abort_at < 0) ? len + lat + 3 : abort_at + 4;

    @(negedge clk);
    frame_len   = 8'(len_cfg);
    dec_latency = 8'(lat_cfg);
    err_period  = 4'(per);
    err_burst   = 4'(bur);
    start       = 1'b1;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      start = (c == restart_at) && (c <= len + lat);
      if (abort_at >= 0) abort = (c == abort_at);
      else               abort = (c == len + lat) || (c == len + lat + 2);
      k = c - lat;
      decoder_o   = (k >= 0 && k < len) ? (tx_ref[k] ^ flip[k]) : 1'($urandom);
      frame_len   = 8'($urandom);
      dec_latency = 8'($urandom);
      err_period  = 4'($urandom);
      err_burst   = 4'($urandom);
      if (abort_at >= 0 && c > abort_at) begin
        check_idle_outputs("aborted");
      end else begin
        check("enable", int'(enable_encoder_i), (c < len) ? 1 : 0);
        check("encoder", int'(encoder_i), (c < len) ? int'(tx_ref[c]) : 0);
        check("err_mask", int'(err_mask),
              (c < len && per != 0 && (c % per) < bur) ? 2 : 0);
        check("busy", int'(busy), (c < len + lat) ? 1 : 0);
        check("done", int'(done), (c == len + lat) ? 1 : 0);
      end
      if ((abort_at < 0 && c == len + lat) || c == last_c) begin
        check("bit_err_ct", int'(bit_err_ct), exp_bit);
        check("chan_err_ct", int'(chan_err_ct), exp_chan);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    $display("frame %0d len=%0d lat=%0d per=%0d bur=%0d abort_at=%0d bit_err=%0d chan_err=%0d",
             frame_no, len, lat, per, bur, abort_at, bit_err_ct, chan_err_ct);
    frame_no++;
  endtask

  task automatic reset_mid_drain();
    @(negedge clk);
    frame_len = 8'd8; dec_latency = 8'd12; err_period = 4'd2; err_burst = 4'd1;
    start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_chan", int'(chan_err_ct), 4);
    rst = 1'b0;
    #1;
    check_idle_outputs("in_reset");
    check("in_reset_bit_err", int'(bit_err_ct), 0);
    check("in_reset_chan_err", int'(chan_err_ct), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("post_reset_done", int'(done), 0);
      check("post_reset_busy", int'(busy), 0);
    end
    $display("frame %0d reset-in-drain bit_err=%0d chan_err=%0d", frame_no, bit_err_ct, chan_err_ct);
    frame_no++;
  endtask

  initial begin
    logic [255:0] fv;
    build_prbs_ref();
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_bit_err", int'(bit_err_ct), 0);
    check("reset_chan_err", int'(chan_err_ct), 0);
    rst = 1'b1;
    @(negedge clk);

    run_frame(16, 5, 0, 0, 0, '0, -1, -1);
    run_frame(32, 3, 8, 3, 0, '0, -1, -1);
    fv = '0;
    fv[3] = 1'b1;
    fv[9] = 1'b1;
    run_frame(16, 5, 0, 0, 0, fv, -1, 3);
    run_frame(16, 5, 4, 1, 10, '0, 4, -1);
    run_frame(16, 5, 0, 0, 0, '0, -1, -1);
    run_frame(0, 7, 3, 1, 5, '0, -1, -1);
    run_frame(10, 0, 0, 0, 20, '0, -1, -1);
    run_frame(0, 2, 4, 15, 0, '0, -1, -1);
    reset_mid_drain();
    run_frame(12, 4, 5, 2, 0, '0, -1, -1);

    for (int n = 0; n < 12; n++) begin
      run_frame(int'($urandom_range(1, 40)), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 15, '0,
                (n % 4 == 3) ? int'($urandom_range(0, 6)) : -1,
                int'($urandom_range(0, 30)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
